// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - 50% duty clock divider with glitch-free ratio change at period boundaries
module clk_div_ctrl #(
   parameter int W       = 8,
   parameter int DEF_DIV = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         req_valid,
   input  logic [W-1:0] req_div,
   output logic         req_ready,
   output logic         clk_out,
   output logic [W-1:0] div_active,
   output logic         busy,
   output logic         period_done,
   output logic         err
);

   typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

   localparam logic [W-1:0] DEF = W'(DEF_DIV);

   state_t       state, state_nxt;
   logic [W-1:0] c, c_nxt, pending, half_m1;
   logic         clk_nxt, fall, apply, xfer, req_ok;

   assign half_m1   = (div_active >> 1) - 1'b1;
   assign req_ready = ~busy;
   assign xfer      = req_valid & req_ready;
   assign req_ok    = ~req_div[0] & (req_div != '0);
   // A pending ratio lands only where it cannot shorten a phase: on the falling edge or while idle.
   assign apply     = busy & ((state == IDLE) | fall);

   always_comb begin
      state_nxt = state;
      c_nxt     = c;
      clk_nxt   = clk_out;
      fall      = 1'b0;
      case (state)
         IDLE: begin
            c_nxt   = '0;
            clk_nxt = 1'b0;
            if (en) state_nxt = RUN;
         end
         RUN, STOP: begin
            if (state == RUN && !en && !clk_out) begin
               state_nxt = IDLE;
               c_nxt     = '0;
            end else begin
               if (c == half_m1) begin
                  c_nxt   = '0;
                  clk_nxt = ~clk_out;
                  fall    = clk_out;
               end else begin
                  c_nxt = c + 1'b1;
               end
               // Only reachable with clk_out high when en is low: finish the high phase first.
               if (!en) state_nxt = fall ? IDLE : STOP;
               else     state_nxt = RUN;
            end
         end
         default: begin
            state_nxt = IDLE;
            c_nxt     = '0;
            clk_nxt   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         c           <= '0;
         clk_out     <= 1'b0;
         div_active  <= DEF;
         pending     <= DEF;
         busy        <= 1'b0;
         period_done <= 1'b0;
         err         <= 1'b0;
      end else begin
         state       <= state_nxt;
         c           <= c_nxt;
         clk_out     <= clk_nxt;
         period_done <= fall;
         err         <= xfer & ~req_ok;
         if (apply) begin
            div_active <= pending;
            busy       <= 1'b0;
         end else if (xfer && req_ok) begin
            pending <= req_div;
            busy    <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - directed self-checking bench for clk_div_ctrl
module tb_clk_div_ctrl;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst, en, req_valid;
   logic [W-1:0] req_div;
   logic         req_ready, clk_out, busy, period_done, err;
   logic [W-1:0] div_active;
   logic [7:0]   exp_clk, exp_pd;
   int           checks   = 0;
   int           failures = 0;

   clk_div_ctrl #(.W(W), .DEF_DIV(4)) dut (
      .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_div(req_div),
      .req_ready(req_ready), .clk_out(clk_out), .div_active(div_active),
      .busy(busy), .period_done(period_done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; req_valid = 1'b0; req_div = '0;
      tick(); tick();
      chk("rst_clk_out", 32'(clk_out), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ready", 32'(req_ready), 1);
      chk("rst_div", 32'(div_active), 4);
      chk("rst_pd", 32'(period_done), 0);
      chk("rst_err", 32'(err), 0);

      // default ratio 4
      rst = 1'b1; en = 1'b1;
      exp_clk = 8'b1100_1100;
      exp_pd  = 8'b0001_0000;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("div4_clk", 32'(clk_out), 32'(exp_clk[i]));
         chk("div4_pd", 32'(period_done), 32'(exp_pd[i]));
      end
      tick(); tick(); tick();
      chk("div4_high", 32'(clk_out), 1);

      // ratio 10 offered in the high phase
      req_valid = 1'b1; req_div = 8'd10;
      tick();
      req_valid = 1'b0;
      chk("r10_busy", 32'(busy), 1);
      chk("r10_ready", 32'(req_ready), 0);
      chk("r10_div_old", 32'(div_active), 4);
      chk("r10_still_high", 32'(clk_out), 1);
      tick();
      chk("r10_div_new", 32'(div_active), 10);
      chk("r10_busy_clr", 32'(busy), 0);
      chk("r10_pd", 32'(period_done), 1);
      chk("r10_low0", 32'(clk_out), 0);
      for (int i = 1; i < 10; i++) begin
         tick();
         chk("r10_phase", 32'(clk_out), (i >= 5) ? 1 : 0);
      end
      tick();
      chk("r10_fall", 32'(clk_out), 0);
      chk("r10_fall_pd", 32'(period_done), 1);

      // invalid ratios 7 and 0
      req_valid = 1'b1; req_div = 8'd7;
      tick();
      req_valid = 1'b0;
      chk("odd_err", 32'(err), 1);
      chk("odd_busy", 32'(busy), 0);
      tick();
      chk("odd_err_once", 32'(err), 0);
      req_valid = 1'b1; req_div = 8'd0;
      tick();
      req_valid = 1'b0;
      chk("zero_err", 32'(err), 1);
      chk("zero_busy", 32'(busy), 0);
      chk("zero_div", 32'(div_active), 10);
      tick();
      chk("zero_err_once", 32'(err), 0);
      chk("zero_div_kept", 32'(div_active), 10);

      // switch to 6, then stop during the high phase
      req_valid = 1'b1; req_div = 8'd6;
      tick();
      req_valid = 1'b0;
      chk("r6_busy", 32'(busy), 1);
      chk("r6_rise", 32'(clk_out), 1);
      tick(); tick(); tick(); tick();
      chk("r6_high_end", 32'(clk_out), 1);
      chk("r6_div_old", 32'(div_active), 10);
      tick();
      chk("r6_div_new", 32'(div_active), 6);
      chk("r6_fall", 32'(clk_out), 0);
      chk("r6_busy_clr", 32'(busy), 0);
      tick(); tick();
      chk("r6_low", 32'(clk_out), 0);
      tick();
      chk("r6_rise2", 32'(clk_out), 1);
      tick();
      en = 1'b0;
      tick();
      chk("stop_high", 32'(clk_out), 1);
      tick();
      chk("stop_fall", 32'(clk_out), 0);
      chk("stop_pd", 32'(period_done), 1);
      tick();
      chk("stop_idle", 32'(clk_out), 0);
      chk("stop_idle_pd", 32'(period_done), 0);
      tick();

      // en dropped during the low phase
      en = 1'b1;
      tick(); tick();
      en = 1'b0;
      tick(); tick();
      chk("low_drop_idle", 32'(clk_out), 0);
      tick(); tick();
      chk("low_drop_hold", 32'(clk_out), 0);
      chk("low_drop_pd", 32'(period_done), 0);

      // back-to-back 8 then 2
      en = 1'b1;
      tick();
      req_valid = 1'b1; req_div = 8'd8;
      tick();
      req_div = 8'd2;
      chk("b2b_busy8", 32'(busy), 1);
      chk("b2b_ready8", 32'(req_ready), 0);
      tick(); tick(); tick(); tick();
      chk("b2b_wait_busy", 32'(busy), 1);
      chk("b2b_wait_div", 32'(div_active), 6);
      chk("b2b_wait_high", 32'(clk_out), 1);
      tick();
      chk("b2b_div8", 32'(div_active), 8);
      chk("b2b_apply_ready", 32'(req_ready), 1);
      chk("b2b_fall", 32'(clk_out), 0);
      tick();
      req_valid = 1'b0;
      chk("b2b_busy2", 32'(busy), 1);
      chk("b2b_div8_kept", 32'(div_active), 8);
      tick(); tick();
      chk("b2b_low8", 32'(clk_out), 0);
      tick();
      chk("b2b_rise8", 32'(clk_out), 1);
      tick(); tick(); tick();
      chk("b2b_high8", 32'(clk_out), 1);
      tick();
      chk("b2b_div2", 32'(div_active), 2);
      chk("b2b_fall8", 32'(clk_out), 0);
      chk("b2b_busy_clr", 32'(busy), 0);
      exp_clk = 8'b0000_0101;
      exp_pd  = 8'b0000_1010;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("div2_clk", 32'(clk_out), 32'(exp_clk[i]));
         chk("div2_pd", 32'(period_done), 32'(exp_pd[i]));
      end

      // async reset mid-high-phase with a ratio pending
      req_valid = 1'b1; req_div = 8'd10;
      tick();
      req_valid = 1'b0;
      chk("ar_pre_high", 32'(clk_out), 1);
      chk("ar_pre_busy", 32'(busy), 1);
      #2;
      rst = 1'b0;
      en  = 1'b0;
      #1;
      chk("ar_clk_out", 32'(clk_out), 0);
      chk("ar_busy", 32'(busy), 0);
      chk("ar_ready", 32'(req_ready), 1);
      chk("ar_div", 32'(div_active), 4);
      tick();
      rst = 1'b1;
      tick(); tick();
      chk("ar_discard_div", 32'(div_active), 4);
      chk("ar_discard_busy", 32'(busy), 0);
      chk("ar_idle_clk", 32'(clk_out), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 SHALL have parameter W, default 8, giving the width of the divide-ratio fields.
REQ-002 SHALL have parameter DEF_DIV, default 4, giving the divide ratio loaded at reset; it must be even and at least 2.
REQ-003 SHALL have port: clk  input  1  single clock; every register is clocked on its rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: en  input  1  run request for the divided clock.
REQ-006 SHALL have port: req_valid  input  1  a new divide ratio is offered.
REQ-007 SHALL have port: req_div  input  W  offered divide ratio N.
REQ-008 SHALL have port: req_ready  output  1  the block can accept a ratio this cycle.
REQ-009 SHALL have port: clk_out  output  1  divided clock, 50% duty.
REQ-010 SHALL have port: div_active  output  W  divide ratio currently in force.
REQ-011 SHALL have port: busy  output  1  a ratio has been accepted but not yet applied.
REQ-012 SHALL have port: period_done  output  1  one-cycle pulse on every clk_out 1->0 transition.
REQ-013 SHALL have port: err  output  1  one-cycle pulse when an invalid ratio is offered.

Function
REQ-014 SHALL define half-period H = div_active/2; counter c counts 0..H-1 while clk_out runs.
REQ-015 SHALL, in RUN, toggle clk_out and clear c when c==H-1; otherwise increment c, so clk_out period is exactly div_active clk cycles.
REQ-016 SHALL implement states IDLE, RUN and STOP; clk_out is 0 and c is 0 throughout IDLE.
REQ-017 SHALL move IDLE->RUN when en==1; the first clk_out rise occurs H cycles after entering RUN.
REQ-018 SHALL move RUN->IDLE directly when en==0 while clk_out==0, clearing c; RUN->STOP when en==0 while clk_out==1.
REQ-019 SHALL, in STOP, finish the high phase: at c==H-1 drive clk_out to 0, pulse period_done, go to IDLE; en==1 during STOP returns to RUN with no truncation of the high phase.
REQ-020 SHALL drive req_ready = ~busy; a transfer occurs when req_valid && req_ready.
REQ-021 SHALL treat req_div as valid only if even and >=2; an invalid transfer pulses err next cycle, is discarded and leaves busy unchanged.
REQ-022 SHALL, on a valid transfer, store req_div in a pending register and set busy.
REQ-023 SHALL apply a pending ratio only at a period boundary: in RUN/STOP on the clk_out 1->0 transition (div_active <= pending, c <= 0, busy <= 0), or in IDLE on the cycle after acceptance.
REQ-024 SHALL never produce a clk_out high or low phase shorter than min(old H, new H) clk cycles across a ratio change.
REQ-025 SHALL not accept a new ratio in the cycle that applies a pending one (req_ready is 0 that cycle); it is accepted the next cycle.
REQ-026 SHALL treat N==2 (H==1) as toggling clk_out every cycle, i.e. clk_out = clk/2.

Reset
REQ-027 SHALL, when rst==0, asynchronously force state=IDLE, c=0, clk_out=0, div_active=DEF_DIV, busy=0, req_ready=1, period_done=0, err=0.
REQ-028 SHALL discard any pending ratio on reset, including mid-period or mid-STOP.
REQ-029 SHALL leave reset synchronously to clk; the first state change occurs on the first rising edge with rst==1.

Verification
REQ-030 SHALL cover: reset release, en=1, DEF_DIV=4 -> clk_out 0,0,1,1,0,0,1,1...; period_done pulses every 4 cycles.
REQ-031 SHALL cover: running at N=4, valid transfer of 10 mid-high-phase -> busy=1 until the next 1->0 edge; then high/low phases of 5 cycles; div_active=10.
REQ-032 SHALL cover: req_div=7 and req_div=0 offered -> err pulses once each; div_active and busy unchanged.
REQ-033 SHALL cover: N=6, en dropped one cycle after clk_out rises -> high phase lasts the full 3 cycles, then clk_out=0 in IDLE; en dropped during the low phase -> immediate IDLE with clk_out held at 0.
REQ-034 SHALL cover: req_valid held high with 8 then 2 back-to-back -> 8 applied at the boundary, 2 accepted one cycle later and applied at the following boundary; no phase shorter than 1 cycle.
REQ-035 SHALL cover: rst asserted mid-high-phase with a ratio pending -> clk_out=0, busy=0, div_active=DEF_DIV immediately, without waiting for a clk edge.
